// File: rtl/motor_cmd_ramp_pkg.sv
// Shared widths, drive-mode constants and ramp FSM encoding for the per-motor
// command path (SPI receive logic, motor_cmd_ramp, motor).
package motor_cmd_ramp_pkg;

  localparam int SPEED_W = 9;
  localparam int MODE_W  = 2;

  localparam logic [MODE_W-1:0] DRIVE_COAST = 2'b00;

  typedef enum logic [1:0] {
    ST_STEADY = 2'd0,
    ST_RAMP   = 2'd1,
    ST_BRAKE  = 2'd2,
    ST_DWELL  = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/motor_cmd_ramp_step.sv
// One slew step of a 9-bit magnitude toward a goal, clamped so it never
// overshoots; reached is high when the result equals the goal.
module ramp_step
  import motor_cmd_ramp_pkg::*;
(
  input  logic [SPEED_W-1:0] cur,
  input  logic [SPEED_W-1:0] goal,
  input  logic [SPEED_W-1:0] step,
  output logic [SPEED_W-1:0] nxt,
  output logic               reached
);

  logic signed [SPEED_W:0] diff;
  logic        [SPEED_W:0] mag;

  always_comb begin
    diff    = $signed({1'b0, goal}) - $signed({1'b0, cur});
    mag     = diff[SPEED_W] ? $unsigned(-diff) : $unsigned(diff);
    nxt     = goal;
    reached = 1'b1;
    // A full step only when it cannot cross the goal, so no wrap is possible.
    if (mag > {1'b0, step}) begin
      reached = 1'b0;
      nxt     = diff[SPEED_W] ? (cur - step) : (cur + step);
    end
  end

endmodule

// File: rtl/motor_cmd_ramp.sv
// Per-motor command slew limiter: latches SPI targets and walks the applied
// speed toward them one bounded step per PWM period, braking and dwelling at 0 on reversal.
module motor_cmd_ramp
  import motor_cmd_ramp_pkg::*;
#(
  parameter int STEP        = 8,
  parameter int DWELL_TICKS = 4
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               pwm_tick,
  input  logic               cmd_valid,
  input  logic               kill,
  input  logic               tgt_dir,
  input  logic [SPEED_W-1:0] tgt_speed,
  input  logic [MODE_W-1:0]  tgt_mode,
  output logic               out_dir,
  output logic [SPEED_W-1:0] out_speed,
  output logic [MODE_W-1:0]  out_mode,
  output logic               at_target,
  output ramp_state_t        dbg_state
);

  // pwm_tick and cmd_valid are single-cycle strobes with no back-pressure:
  // every strobe seen while kill is low is consumed in the cycle it is high.

  localparam logic [SPEED_W-1:0] STEP_C  = SPEED_W'(STEP);
  localparam logic [7:0]         DWELL_C = 8'(DWELL_TICKS);

  ramp_state_t        state, nxt_state;
  logic [7:0]         dwell_cnt, nxt_cnt;
  logic               lat_dir, nxt_dir;
  logic [SPEED_W-1:0] lat_speed, nxt_speed;
  logic [SPEED_W-1:0] tgt_nxt, zero_nxt;
  logic               tgt_reached, zero_reached;
  logic               reversal, mismatch, nxt_at;
  logic               eff_dir;
  logic [SPEED_W-1:0] eff_speed;

  ramp_step u_to_tgt (
    .cur     (out_speed),
    .goal    (lat_speed),
    .step    (STEP_C),
    .nxt     (tgt_nxt),
    .reached (tgt_reached)
  );

  ramp_step u_to_zero (
    .cur     (out_speed),
    .goal    ('0),
    .step    (STEP_C),
    .nxt     (zero_nxt),
    .reached (zero_reached)
  );

  always_comb begin
    nxt_state = state;
    nxt_speed = out_speed;
    nxt_dir   = out_dir;
    nxt_cnt   = dwell_cnt;
    reversal  = (lat_dir != out_dir) && (lat_speed != '0) && (out_speed != '0);
    mismatch  = (lat_speed != out_speed) || ((lat_speed != '0) && (lat_dir != out_dir));
    if (pwm_tick) begin
      if (state == ST_DWELL) begin
        if (lat_speed == '0) begin
          nxt_state = ST_STEADY;
          nxt_cnt   = '0;
        end else if (lat_dir == out_dir) begin
          nxt_state = ST_RAMP;
          nxt_cnt   = '0;
        end else if (dwell_cnt <= 8'd1) begin
          nxt_dir   = lat_dir;
          nxt_state = ST_RAMP;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = dwell_cnt - 8'd1;
        end
      end else if (reversal) begin
        nxt_speed = zero_nxt;
        if (zero_reached) begin
          nxt_state = ST_DWELL;
          nxt_cnt   = DWELL_C;
        end else begin
          nxt_state = ST_BRAKE;
        end
      end else if ((state != ST_STEADY) || mismatch) begin
        // Starting from standstill the new direction is free to take immediately.
        nxt_speed = tgt_nxt;
        if ((out_speed == '0) && (lat_speed != '0)) nxt_dir = lat_dir;
        nxt_state = tgt_reached ? ST_STEADY : ST_RAMP;
      end
    end
    eff_dir   = cmd_valid ? tgt_dir   : lat_dir;
    eff_speed = cmd_valid ? tgt_speed : lat_speed;
    nxt_at    = (nxt_state == ST_STEADY) && (nxt_speed == eff_speed) &&
                ((eff_speed == '0) || (nxt_dir == eff_dir));
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= ST_STEADY;
      dwell_cnt <= '0;
      lat_dir   <= 1'b0;
      lat_speed <= '0;
      out_dir   <= 1'b0;
      out_speed <= '0;
      out_mode  <= DRIVE_COAST;
      at_target <= 1'b1;
    end else if (kill) begin
      state     <= ST_STEADY;
      dwell_cnt <= '0;
      lat_speed <= '0;
      out_speed <= '0;
      out_mode  <= DRIVE_COAST;
      at_target <= 1'b1;
    end else begin
      state     <= nxt_state;
      dwell_cnt <= nxt_cnt;
      out_dir   <= nxt_dir;
      out_speed <= nxt_speed;
      at_target <= nxt_at;
      if (cmd_valid) begin
        lat_dir   <= tgt_dir;
        lat_speed <= tgt_speed;
        out_mode  <= tgt_mode;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Self-checking bench for motor_cmd_ramp: directed scenarios plus a random
// phase, all checked against a per-tick arithmetic model of the slew rules.
module tb_motor_cmd_ramp;
  import motor_cmd_ramp_pkg::*;

  localparam int STEP  = 8;
  localparam int DWELL = 4;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        kill = 1'b0;
  logic        tgt_dir = 1'b0;
  logic [8:0]  tgt_speed = '0;
  logic [1:0]  tgt_mode = '0;
  logic        out_dir;
  logic [8:0]  out_speed;
  logic [1:0]  out_mode;
  logic        at_target;
  ramp_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  int m_dir, m_sp, m_mode, m_tdir, m_tsp, m_dwell;
  bit m_settled, m_at;

  motor_cmd_ramp #(.STEP(STEP), .DWELL_TICKS(DWELL)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .pwm_tick  (pwm_tick),
    .cmd_valid (cmd_valid),
    .kill      (kill),
    .tgt_dir   (tgt_dir),
    .tgt_speed (tgt_speed),
    .tgt_mode  (tgt_mode),
    .out_dir   (out_dir),
    .out_speed (out_speed),
    .out_mode  (out_mode),
    .at_target (at_target),
    .dbg_state (dbg_state)
  );

  always #27 sysclk = ~sysclk;

  function automatic void model_reset();
    m_dir = 0; m_sp = 0; m_mode = 0; m_tdir = 0; m_tsp = 0; m_dwell = 0;
    m_settled = 1'b1; m_at = 1'b1;
  endfunction

  // One PWM period of the slew rules, acting on the currently latched target.
  function automatic void model_tick();
    if (m_dwell > 0) begin
      if (m_tsp == 0) begin m_dwell = 0; m_settled = 1'b1; end
      else if (m_tdir == m_dir) begin m_dwell = 0; m_settled = 1'b0; end
      else if (m_dwell == 1) begin m_dir = m_tdir; m_dwell = 0; m_settled = 1'b0; end
      else m_dwell = m_dwell - 1;
    end else if (m_tdir != m_dir && m_tsp != 0 && m_sp != 0) begin
      m_sp = (m_sp > STEP) ? m_sp - STEP : 0;
      m_settled = 1'b0;
      if (m_sp == 0) m_dwell = DWELL;
    end else begin
      if (m_sp == 0 && m_tsp != 0) m_dir = m_tdir;
      if (m_tsp > m_sp + STEP) m_sp = m_sp + STEP;
      else if (m_tsp + STEP < m_sp) m_sp = m_sp - STEP;
      else m_sp = m_tsp;
      m_settled = (m_sp == m_tsp);
    end
  endfunction

  // Drive one clock cycle of inputs from a negedge, update the model at the
  // posedge, and return at the following negedge with outputs settled.
  task automatic cycle(input bit tick, input bit cv, input bit d, input int s, input int m);
    pwm_tick  = tick;
    cmd_valid = cv;
    tgt_dir   = d;
    tgt_speed = 9'(s);
    tgt_mode  = 2'(m);
    @(posedge sysclk);
    if (kill) begin
      m_sp = 0; m_mode = 0; m_tsp = 0; m_dwell = 0; m_settled = 1'b1;
    end else begin
      if (tick) model_tick();
      if (cv) begin m_tdir = d; m_tsp = s; m_mode = m; end
    end
    m_at = m_settled && (m_dwell == 0) && (m_sp == m_tsp) && (m_tsp == 0 || m_dir == m_tdir);
    @(negedge sysclk);
    pwm_tick  = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic tick_once();
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; kill = 1'b0;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (out_speed !== 9'd0 || out_dir !== 1'b0 || out_mode !== 2'd0 || at_target !== 1'b1 || dbg_state !== ST_STEADY) begin
      n_fail++;
      $display("FAIL reset: spd=%0d dir=%0d mode=%0d at=%0d st=%0d, want 0/0/0/1/0", out_speed, out_dir, out_mode, at_target, dbg_state);
    end
    rst = 1'b0;
    model_reset();
    @(negedge sysclk);
  endtask

  task automatic test_ramp_up();
    int exp;
    cycle(0, 1, 0, 100, 1);
    n_checks++;
    if (out_mode !== 2'd1 || out_speed !== 9'd0) begin
      n_fail++;
      $display("FAIL mode_latch: mode=%0d spd=%0d, want 1/0", out_mode, out_speed);
    end
    for (int i = 1; i <= 13; i++) begin
      tick_once();
      exp = (8 * i > 100) ? 100 : 8 * i;
      n_checks++;
      if (out_speed !== 9'(exp) || at_target !== (i == 13) || out_speed !== 9'(m_sp) || at_target !== m_at) begin
        n_fail++;
        $display("FAIL ramp_up tick %0d: spd=%0d at=%0d, want %0d/%0d (model %0d/%0d)", i, out_speed, at_target, exp, (i == 13), m_sp, m_at);
      end
    end
  endtask

  task automatic test_reversal();
    int exp;
    cycle(0, 1, 1, 50, 1);
    for (int i = 1; i <= 13; i++) begin
      tick_once();
      exp = (100 - 8 * i < 0) ? 0 : 100 - 8 * i;
      n_checks++;
      if (out_speed !== 9'(exp) || out_dir !== 1'b0 || at_target !== 1'b0) begin
        n_fail++;
        $display("FAIL brake tick %0d: spd=%0d dir=%0d at=%0d, want %0d/0/0", i, out_speed, out_dir, at_target, exp);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      tick_once();
      n_checks++;
      if (out_speed !== 9'd0 || out_dir !== (i == 4)) begin
        n_fail++;
        $display("FAIL dwell tick %0d: spd=%0d dir=%0d, want 0/%0d", i, out_speed, out_dir, (i == 4));
      end
    end
    for (int i = 1; i <= 7; i++) begin
      tick_once();
      exp = (8 * i > 50) ? 50 : 8 * i;
      n_checks++;
      if (out_speed !== 9'(exp) || out_dir !== 1'b1 || at_target !== (i == 7)) begin
        n_fail++;
        $display("FAIL reramp tick %0d: spd=%0d dir=%0d at=%0d, want %0d/1/%0d", i, out_speed, out_dir, at_target, exp, (i == 7));
      end
    end
  endtask

  task automatic test_kill();
    kill = 1'b1; cycle(0, 0, 0, 0, 0); kill = 1'b0;
    cycle(0, 1, 1, 200, 2);
    repeat (5) tick_once();
    n_checks++;
    if (out_speed !== 9'd40 || out_mode !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_kill: spd=%0d mode=%0d, want 40/2", out_speed, out_mode);
    end
    kill = 1'b1;
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (out_speed !== 9'd0 || out_mode !== 2'd0 || out_dir !== 1'b1) begin
      n_fail++;
      $display("FAIL kill: spd=%0d mode=%0d dir=%0d, want 0/0/1", out_speed, out_mode, out_dir);
    end
    cycle(1, 1, 0, 300, 3);
    n_checks++;
    if (out_speed !== 9'd0 || out_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL kill_cmd_ignored: spd=%0d mode=%0d, want 0/0", out_speed, out_mode);
    end
    kill = 1'b0;
    repeat (3) tick_once();
    n_checks++;
    if (out_speed !== 9'd0 || at_target !== 1'b1 || out_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL post_kill: spd=%0d at=%0d mode=%0d, want 0/1/0", out_speed, at_target, out_mode);
    end
  endtask

  task automatic test_coincident();
    cycle(1, 1, 0, 200, 1);
    n_checks++;
    if (out_speed !== 9'd0 || out_mode !== 2'd1) begin
      n_fail++;
      $display("FAIL coincident_tick: spd=%0d mode=%0d, want 0/1", out_speed, out_mode);
    end
    tick_once();
    n_checks++;
    if (out_speed !== 9'd8 || out_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_next: spd=%0d dir=%0d, want 8/0", out_speed, out_dir);
    end
  endtask

  task automatic test_small_clamp();
    int budget;
    kill = 1'b1; cycle(0, 0, 0, 0, 0); kill = 1'b0;
    cycle(0, 1, 0, 3, 1);
    tick_once();
    n_checks++;
    if (out_speed !== 9'd3 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_small: spd=%0d at=%0d, want 3/1", out_speed, at_target);
    end
    cycle(0, 1, 0, 505, 1);
    budget = 0;
    while (at_target !== 1'b1 && budget < 100) begin tick_once(); budget++; end
    n_checks++;
    if (out_speed !== 9'd505 || budget != 63) begin
      n_fail++;
      $display("FAIL ramp_505: spd=%0d ticks=%0d, want 505/63", out_speed, budget);
    end
    cycle(0, 1, 0, 511, 1);
    tick_once();
    n_checks++;
    if (out_speed !== 9'd511 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_511: spd=%0d at=%0d, want 511/1", out_speed, at_target);
    end
  endtask

  task automatic test_dwell_zero();
    int budget;
    cycle(0, 1, 1, 100, 1);
    budget = 0;
    while (out_speed !== 9'd0 && budget < 100) begin tick_once(); budget++; end
    n_checks++;
    if (budget != 64 || dbg_state !== ST_DWELL) begin
      n_fail++;
      $display("FAIL full_brake: ticks=%0d st=%0d, want 64/%0d", budget, dbg_state, ST_DWELL);
    end
    repeat (2) tick_once();
    cycle(0, 1, 1, 0, 1);
    tick_once();
    n_checks++;
    if (dbg_state !== ST_STEADY || out_dir !== 1'b0 || at_target !== 1'b1 || out_speed !== 9'd0) begin
      n_fail++;
      $display("FAIL dwell_zero: st=%0d dir=%0d at=%0d spd=%0d, want 0/0/1/0", dbg_state, out_dir, at_target, out_speed);
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 0, 300, 2);
    repeat (3) tick_once();
    #5 rst = 1'b1;
    #5;
    n_checks++;
    if (out_speed !== 9'd0 || out_mode !== 2'd0 || at_target !== 1'b1 || dbg_state !== ST_STEADY) begin
      n_fail++;
      $display("FAIL async_reset: spd=%0d mode=%0d at=%0d st=%0d, want 0/0/1/0", out_speed, out_mode, at_target, dbg_state);
    end
    @(negedge sysclk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int s;
    bit t, cv;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) kill = ~kill;
      else if (kill && $urandom_range(0, 7) == 0) kill = 1'b0;
      t  = ($urandom_range(0, 3) == 0);
      cv = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: s = 0;
        1: s = 511;
        2: s = $urandom_range(0, 511);
        default: s = $urandom_range(0, 20);
      endcase
      cycle(t, cv, 1'($urandom_range(0, 1)), s, $urandom_range(0, 3));
      n_checks++;
      if (out_speed !== 9'(m_sp) || out_dir !== 1'(m_dir) || out_mode !== 2'(m_mode) || at_target !== m_at) begin
        n_fail++;
        $display("FAIL random cyc %0d: spd=%0d dir=%0d mode=%0d at=%0d, want %0d/%0d/%0d/%0d", i, out_speed, out_dir, out_mode, at_target, m_sp, m_dir, m_mode, m_at);
      end
    end
    kill = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp_up();
    test_reversal();
    test_kill();
    test_coincident();
    test_small_clamp();
    test_dwell_zero();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
